// File: rtl/lcd_text_ctrl.sv
// HD44780 text front end: power-up wait, init commands, then ASCII stream to {rs,data} words.
// Optional macro LCD_TEXT_AUTOWRAP_EN wraps to the next row at end of line instead of saturating.
module lcd_text_ctrl #(
  parameter int unsigned COLS           = 16,
  parameter int unsigned ROWS           = 2,
  parameter int unsigned POWERUP_CYCLES = 1500000
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [7:0]                                 char_i,
  input  logic                                       char_valid_i,
  output logic                                       char_ready_o,
  output logic [8:0]                                 lcd_data_o,
  output logic                                       lcd_valid_o,
  input  logic                                       lcd_ready_i,
  output logic                                       init_done_o,
  output logic [$clog2(COLS)-1:0]                    col_o,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_o
);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [PW-1:0] PWR_TERM = PW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_EMIT_CHAR, S_EMIT_ADDR, S_EMIT_CLR
  } state_t;

  state_t        r_state, w_state;
  logic [PW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_idx, w_idx;
  logic [8:0]    r_data, w_data;
  logic          r_valid, w_valid;
  logic          r_ready, w_ready;
  logic          r_done, w_done;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [RW-1:0] r_nrow, w_nrow;
  logic          r_sat, w_sat;
  logic          w_hs;
  logic          w_printable;
  logic [RW-1:0] w_row_inc;

  function automatic logic [8:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 9'h038;
      2'd1:    init_word = 9'h00C;
      2'd2:    init_word = 9'h001;
      default: init_word = 9'h006;
    endcase
  endfunction

  // Set-DDRAM-address command for the start of a row
  function automatic logic [8:0] addr_word(input logic [RW-1:0] row);
    int unsigned r;
    r = 32'(row);
    addr_word = {1'b0, 8'h80 | 8'((((r & 1) != 0) ? 64 : 0) + (((r & 2) != 0) ? COLS : 0))};
  endfunction

  assign w_hs        = r_valid & lcd_ready_i;
  assign w_printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
  assign w_row_inc   = (ROWS > 1) ? RW'(r_row + RW'(1)) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_PWRUP;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_nrow  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_col   <= w_col;
      r_row   <= w_row;
      r_nrow  <= w_nrow;
      r_sat   <= w_sat;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_data  = r_data;
    w_valid = r_valid;
    w_ready = r_ready;
    w_done  = r_done;
    w_col   = r_col;
    w_row   = r_row;
    w_nrow  = r_nrow;
    w_sat   = r_sat;
    case (r_state)
      S_PWRUP: begin
        if (r_cnt == PWR_TERM) begin
          w_cnt   = '0;
          w_state = S_INIT;
        end else begin
          w_cnt = r_cnt + PW'(1);
        end
      end
      // First cycle in INIT loads word 0; afterwards each handshake loads the next
      S_INIT: begin
        if (!r_valid) begin
          w_valid = 1'b1;
          w_data  = init_word(r_idx);
        end else if (lcd_ready_i) begin
          if (r_idx == 2'd3) begin
            w_valid = 1'b0;
            w_done  = 1'b1;
            w_ready = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_idx  = r_idx + 2'd1;
            w_data = init_word(r_idx + 2'd1);
          end
        end
      end
      S_IDLE: begin
        if (char_valid_i && r_ready) begin
          if (w_printable && !r_sat) begin
            w_ready = 1'b0;
            w_valid = 1'b1;
            w_data  = {1'b1, char_i};
            w_state = S_EMIT_CHAR;
          end else if (char_i == 8'h0A) begin
            w_ready = 1'b0;
            w_valid = 1'b1;
            w_nrow  = w_row_inc;
            w_data  = addr_word(w_row_inc);
            w_state = S_EMIT_ADDR;
          end else if (char_i == 8'h0C) begin
            w_ready = 1'b0;
            w_valid = 1'b1;
            w_data  = 9'h001;
            w_state = S_EMIT_CLR;
          end
        end
      end
      S_EMIT_CHAR: begin
        if (w_hs) begin
          if (r_col == COL_LAST) begin
`ifdef LCD_TEXT_AUTOWRAP_EN
            w_col   = '0;
            w_row   = w_row_inc;
            w_nrow  = w_row_inc;
            w_data  = addr_word(w_row_inc);
            w_state = S_EMIT_ADDR;
`else
            // Column register stays on the last cell; r_sat marks the line as full
            w_sat   = 1'b1;
            w_valid = 1'b0;
            w_ready = 1'b1;
            w_state = S_IDLE;
`endif
          end else begin
            w_col   = r_col + CW'(1);
            w_valid = 1'b0;
            w_ready = 1'b1;
            w_state = S_IDLE;
          end
        end
      end
      S_EMIT_ADDR: begin
        if (w_hs) begin
          w_col   = '0;
          w_row   = r_nrow;
          w_sat   = 1'b0;
          w_valid = 1'b0;
          w_ready = 1'b1;
          w_state = S_IDLE;
        end
      end
      S_EMIT_CLR: begin
        if (w_hs) begin
          w_col   = '0;
          w_row   = '0;
          w_sat   = 1'b0;
          w_valid = 1'b0;
          w_ready = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_PWRUP;
    endcase
  end

  assign char_ready_o = r_ready;
  assign lcd_data_o   = r_data;
  assign lcd_valid_o  = r_valid;
  assign init_done_o  = r_done;
  assign col_o        = r_col;
  assign row_o        = r_row;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: directed literal checks plus random traffic against a queue-based model.
module tb_lcd_text_ctrl;
  localparam int unsigned COLS = 16;
  localparam int unsigned ROWS = 2;
  localparam int unsigned PWR  = 10;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic [8:0] lcd_data_o;
  logic       lcd_valid_o;
  logic       lcd_ready_i;
  logic       init_done_o;
  logic [3:0] col_o;
  logic [0:0] row_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .POWERUP_CYCLES(PWR)) dut (
    .clk_i(clk), .rst_i(rst_i), .char_i(char_i), .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o), .lcd_data_o(lcd_data_o), .lcd_valid_o(lcd_valid_o),
    .lcd_ready_i(lcd_ready_i), .init_done_o(init_done_o), .col_o(col_o), .row_o(row_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected word queue and cursor after all queued words complete
  int q[$];
  int m_col, m_row, m_before;

  function automatic int base_of(input int r);
    return (r % 2) * 64 + (r / 2) * COLS;
  endfunction

  function automatic void model_reset();
    q.delete();
    q.push_back('h038); q.push_back('h00C); q.push_back('h001); q.push_back('h006);
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void model_accept(input int c);
    if (c >= 'h20 && c <= 'h7E) begin
      if (m_col < int'(COLS)) begin
        q.push_back('h100 + c);
        m_col++;
`ifdef LCD_TEXT_AUTOWRAP_EN
        if (m_col == int'(COLS)) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          q.push_back('h080 + base_of(m_row));
        end
`endif
      end
    end else if (c == 'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      q.push_back('h080 + base_of(m_row));
    end else if (c == 'h0C) begin
      q.push_back('h001);
      m_col = 0;
      m_row = 0;
    end
  endfunction

  logic       prev_stall = 1'b0;
  logic [8:0] prev_data  = '0;
  int         exp_next   = -1;

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_i) begin
      model_reset();
      prev_stall = 1'b0;
      exp_next   = -1;
    end else begin
      if (prev_stall) chk("hold", int'({lcd_valid_o, lcd_data_o}), int'({1'b1, prev_data}));
      if (exp_next == 1) chk("accept_busy", int'({lcd_valid_o, char_ready_o}), 2);
      else if (exp_next == 0) chk("accept_drop", int'({lcd_valid_o, char_ready_o}), 1);
      exp_next = -1;
      chk("ready_excl", int'(lcd_valid_o && char_ready_o), 0);
      if (init_done_o && char_ready_o && !lcd_valid_o && q.size() == 0) begin
        chk("col", int'(col_o), (m_col >= int'(COLS)) ? int'(COLS) - 1 : m_col);
        chk("row", int'(row_o), m_row);
      end
      if (lcd_valid_o && lcd_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected: got 0x%0h expected none", lcd_data_o);
        end else begin
          chk("word", int'(lcd_data_o), q.pop_front());
        end
      end
      if (char_valid_i && char_ready_o) begin
        m_before = q.size();
        model_accept(int'(char_i));
        exp_next = (q.size() > m_before) ? 1 : 0;
      end
      prev_stall = lcd_valid_o && !lcd_ready_i;
      prev_data  = lcd_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!char_ready_o && n < limit) begin
      tick();
      n++;
    end
    if (!char_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: char_ready_o still 0 after %0d cycles", limit);
    end
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready(100);
    char_i       = c;
    char_valid_i = 1'b1;
    tick();
    char_valid_i = 1'b0;
  endtask

  initial begin
    int r;
    int n;
    rst_i = 1'b1; char_valid_i = 1'b0; char_i = '0; lcd_ready_i = 1'b1;
    repeat (3) tick();
    chk("reset_values", int'({lcd_data_o, lcd_valid_o, char_ready_o, init_done_o, col_o, row_o}), 0);
    rst_i = 1'b0;
    for (int k = 1; k <= int'(PWR) + 1; k++) begin
      tick();
      if (k == int'(PWR)) chk("pwrup_quiet", int'(lcd_valid_o), 0);
    end
    chk("first_word", int'({lcd_valid_o, lcd_data_o}), 'h238);
    tick(); chk("init_w1", int'(lcd_data_o), 'h00C);
    tick(); chk("init_w2", int'(lcd_data_o), 'h001);
    tick(); chk("init_w3", int'(lcd_data_o), 'h006);
    tick(); chk("init_done", int'({init_done_o, char_ready_o, lcd_valid_o}), 'b110);

    send(8'h41);
    chk("char_A", int'({lcd_valid_o, char_ready_o, lcd_data_o}), 'h541);
    tick(); chk("char_A_col", int'({lcd_valid_o, col_o}), 1);

    lcd_ready_i = 1'b0;
    send(8'h42);
    for (int k = 0; k < 20; k++) begin
      chk("stall_B", int'({lcd_valid_o, char_ready_o, lcd_data_o}), 'h542);
      tick();
    end
    lcd_ready_i = 1'b1;
    tick(); chk("stall_B_done", int'({lcd_valid_o, col_o}), 2);

    send(8'h0C);
    for (int k = 0; k < 16; k++) send(8'h78);
    chk("x16_word", int'({lcd_valid_o, lcd_data_o}), 'h378);
`ifdef LCD_TEXT_AUTOWRAP_EN
    tick(); chk("wrap_addr", int'({lcd_valid_o, lcd_data_o}), 'h2C0);
    tick(); chk("wrap_cursor", int'({row_o, col_o}), 'h10);
`else
    tick(); chk("sat_cursor", int'({row_o, col_o}), 'h0F);
    send(8'h78);
    chk("sat_drop", int'({lcd_valid_o, char_ready_o}), 1);
    tick(); chk("sat_cursor2", int'({row_o, col_o}), 'h0F);
    send(8'h0A);
    chk("lf_row1", int'({lcd_valid_o, lcd_data_o}), 'h2C0);
    tick(); chk("lf_row1_cur", int'({row_o, col_o}), 'h10);
`endif
    send(8'h0A);
    chk("lf_word", int'({lcd_valid_o, lcd_data_o}), 'h280);
    tick(); chk("lf_cursor", int'({row_o, col_o}), 0);

    send(8'h51);
    send(8'h0C);
    chk("ff_word", int'({lcd_valid_o, lcd_data_o}), 'h201);
    tick(); chk("ff_cursor", int'({row_o, col_o}), 0);

    send(8'h07);
    chk("bel_drop", int'({lcd_valid_o, char_ready_o}), 1);

    // Random traffic with random backpressure
    repeat (3000) begin
      lcd_ready_i  = ($urandom % 4) != 0;
      char_valid_i = ($urandom % 2) != 0;
      r = int'($urandom % 16);
      if (r < 11)       char_i = 8'($urandom_range(32, 126));
      else if (r < 13)  char_i = 8'h0A;
      else if (r == 13) char_i = 8'h0C;
      else              char_i = 8'($urandom % 32);
      tick();
    end
    char_valid_i = 1'b0;
    lcd_ready_i  = 1'b1;
    wait_ready(100);

    // Reset while a character word is pending
    lcd_ready_i = 1'b0;
    send(8'h5A);
    chk("midrst_pending", int'({lcd_valid_o, lcd_data_o}), 'h35A);
    rst_i = 1'b1;
    tick();
    chk("midrst_values", int'({lcd_data_o, lcd_valid_o, char_ready_o, init_done_o, col_o, row_o}), 0);
    rst_i = 1'b0;
    lcd_ready_i = 1'b1;
    n = 0;
    while (!lcd_valid_o && n < int'(PWR) + 5) begin
      tick();
      n++;
    end
    chk("rerun_first", int'({lcd_valid_o, lcd_data_o}), 'h238);
    chk("rerun_latency", n, int'(PWR) + 1);
    wait_ready(100);
    send(8'h41);
    wait_ready(100);
    tick();
    chk("final_cursor", int'({row_o, col_o}), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
